scaling_compression_pipe: RTL and testbench

SCALING_COMPRESSION_PIPE -- requirements
Module: scaling_compression_pipe

---
 rtl/scaling_compression_pipe.sv | 101 ++++++++++
 tb/tb_scaling_compression_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaling_compression_pipe.sv
// Two-stage scaling/compression pipe: per lane, (z + c) mod 2^ALPHA >> (ALPHA-BETA).
// Define SC_ROUND_EN to add a half-LSB bias before the shift (round-to-nearest).
module scaling_compression_pipe #(
  parameter int GAMMA     = 13,
  parameter int ALPHA     = 24,
  parameter int BETA      = 16,
  parameter int LANES     = 4,
  parameter int BLOCK_LEN = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   c_load,
  input  logic [ALPHA-1:0]       c_value,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*GAMMA-1:0] s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LANES*BETA-1:0]  m_data,
  output logic                   m_last
);

  localparam int SHIFT = ALPHA - BETA;
  localparam int BEATS = BLOCK_LEN / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] TERM = CW'(BEATS - 1);

`ifdef SC_ROUND_EN
  localparam logic [ALPHA-1:0] BIAS = ALPHA'(1) << (SHIFT - 1);
`else
  localparam logic [ALPHA-1:0] BIAS = '0;
`endif

  logic [ALPHA-1:0]       c_q;
  logic [CW-1:0]          cnt_q;
  logic                   s1_valid_q;
  logic                   s1_last_q;
  logic [LANES*ALPHA-1:0] s1_sum_q;
  logic [LANES*ALPHA-1:0] s1_sum_d;
  logic                   m_valid_q;
  logic                   m_last_q;
  logic [LANES*BETA-1:0]  m_data_q;
  logic [LANES*BETA-1:0]  m_data_d;

  logic enable;
  logic s1_adv;
  logic accept;

  // Stage 1 may also refill while stage 2 is stalled, as long as it is empty.
  assign enable  = !m_valid_q | m_ready;
  assign s1_adv  = !s1_valid_q | enable;
  assign s_ready = s1_adv;
  assign accept  = s_valid & s_ready;

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    s1_sum_d = '0;
    m_data_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_sum_d[i*ALPHA +: ALPHA] = ALPHA'(s_data[i*GAMMA +: GAMMA]) + c_q + BIAS;
      m_data_d[i*BETA +: BETA]   = s1_sum_q[i*ALPHA + SHIFT +: BETA];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q        <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sum_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
    end else begin
      if (c_load) c_q <= c_value;

      if (s1_adv) begin
        s1_valid_q <= accept;
        s1_last_q  <= accept & (cnt_q == TERM);
        if (accept) s1_sum_q <= s1_sum_d;
      end

      if (accept) cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + 1'b1;

      if (enable) begin
        m_valid_q <= s1_valid_q;
        m_last_q  <= s1_valid_q & s1_last_q;
        if (s1_valid_q) m_data_q <= m_data_d;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_scaling_compression_pipe.sv
// Self-checking bench for scaling_compression_pipe: directed vector table plus
// streaming, backpressure, c_load coincidence and mid-flight reset sequences.
module tb_scaling_compression_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_load;
  logic [23:0] c_value;
  logic        s_valid;
  logic        s_ready;
  logic [51:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;

  int checks   = 0;
  int failures = 0;

  scaling_compression_pipe dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .c_load  (c_load),
    .c_value (c_value),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic: (z + c) mod 2^24, optional half-LSB bias, keep bits [23:8].
  function automatic logic [15:0] lane_res(input logic [23:0] c, input logic [12:0] z);
    logic [23:0] s;
    s = 24'(z) + c;
`ifdef SC_ROUND_EN
    s = s + 24'h000080;
`endif
    return s[23:8];
  endfunction

  function automatic logic [63:0] model(input logic [23:0] c, input logic [51:0] z);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = lane_res(c, z[i*13 +: 13]);
    return r;
  endfunction

  function automatic logic [51:0] pat(input int i);
    logic [12:0] a, b, c, d;
    a = 13'(i);
    b = 13'(8191 - i * 3);
    c = 13'(i * 97 + 5);
    d = 13'(i * 1013);
    return {d, c, b, a};
  endfunction

  // Scoreboard: expected beats are queued on acceptance and popped on output transfer.
  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] mdl_c;
  int          mdl_cnt;
  int          out_cnt;
  int          last_cnt;
  int          last_idx;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      mdl_c    = '0;
      mdl_cnt  = 0;
      out_cnt  = 0;
      last_cnt = 0;
      last_idx = -1;
    end else begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_spurious: output beat 0x%0h with no beat outstanding", m_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", m_data, e.data);
          check("sb_last", 64'(m_last), 64'(e.last));
        end
        if (m_last) begin
          last_cnt++;
          last_idx = out_cnt;
        end
        out_cnt++;
      end
      if (s_valid && s_ready) begin
        e.data = model(mdl_c, s_data);
        e.last = (mdl_cnt == 63);
        exp_q.push_back(e);
        mdl_cnt = (mdl_cnt == 63) ? 0 : mdl_cnt + 1;
      end
      if (c_load) mdl_c = c_value;
    end
  end

  typedef struct {
    logic [23:0] c;
    logic [51:0] z;
    logic [63:0] exp_trunc;
    logic [63:0] exp_round;
  } vec_t;

  vec_t vecs[5];

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 20 && (exp_q.size() != 0 || m_valid); k++) tick();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_c(input logic [23:0] c);
    c_load  = 1'b1;
    c_value = c;
    tick();
    c_load  = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_v;
    logic [63:0] snap;
    int          sent;
    int          cyc;
    bit          acc;
    bit          cl_done;

    vecs[0] = '{24'h000100, {13'h1000, 13'h0001, 13'h0000, 13'h1FFF},
                {16'h0011, 16'h0001, 16'h0001, 16'h0020},
                {16'h0011, 16'h0001, 16'h0001, 16'h0021}};
    vecs[1] = '{24'hFFFF00, {13'h1FFF, 13'h0100, 13'h00FF, 13'h0200},
                {16'h001E, 16'h0000, 16'hFFFF, 16'h0001},
                {16'h001F, 16'h0000, 16'h0000, 16'h0001}};
    vecs[2] = '{24'h000000, {13'h1FFF, 13'h0080, 13'h007F, 13'h0000},
                {16'h001F, 16'h0000, 16'h0000, 16'h0000},
                {16'h0020, 16'h0001, 16'h0000, 16'h0000}};
    vecs[3] = '{24'hABCDEF, {13'h0F0F, 13'h1F00, 13'h0011, 13'h1234},
                {16'hABDC, 16'hABEC, 16'hABCE, 16'hABE0},
                {16'hABDD, 16'hABED, 16'hABCE, 16'hABE0}};
    vecs[4] = '{24'hFFFFFF, {13'h0101, 13'h0000, 13'h1FFF, 13'h0001},
                {16'h0001, 16'hFFFF, 16'h001F, 16'h0000},
                {16'h0001, 16'h0000, 16'h0020, 16'h0000}};

    rst_n   = 1'b0;
    c_load  = 1'b0;
    c_value = '0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (2) tick();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Directed vectors: c load, single beat, two-cycle latency, lane values.
    for (int v = 0; v < 5; v++) begin
`ifdef SC_ROUND_EN
      exp_v = vecs[v].exp_round;
`else
      exp_v = vecs[v].exp_trunc;
`endif
      load_c(vecs[v].c);
      s_valid = 1'b1;
      s_data  = vecs[v].z;
      check("tbl_s_ready", 64'(s_ready), 64'd1);
      tick();
      s_valid = 1'b0;
      check("tbl_lat1_m_valid", 64'(m_valid), 64'd0);
      tick();
      check("tbl_lat2_m_valid", 64'(m_valid), 64'd1);
      check("tbl_data", m_data, exp_v);
      tick();
    end
    drain("tbl_drain");

    // 64 back-to-back beats: one m_last on beat 63.
    do_reset();
    load_c(24'hF7F0A5);
    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b1;
      s_data  = pat(i);
      if (!s_ready) check("b2b_s_ready", 64'(s_ready), 64'd1);
      tick();
    end
    drain("b2b_drain");
    check("b2b_out_cnt", 64'(out_cnt), 64'd64);
    check("b2b_last_cnt", 64'(last_cnt), 64'd1);
    check("b2b_last_idx", 64'(last_idx), 64'd63);

    // Second block with a 5-cycle stall and a mid-stream c_load.
    sent    = 0;
    cyc     = 0;
    cl_done = 1'b0;
    snap    = '0;
    while (sent < 64 && cyc < 400) begin
      s_valid = 1'b1;
      s_data  = pat(sent + 64);
      m_ready = !(cyc >= 12 && cyc < 17);
      c_load  = (sent == 30) && !cl_done;
      c_value = 24'h012345;
      if (c_load) cl_done = 1'b1;
      #1;
      if (cyc == 12) begin
        check("stall_m_valid_start", 64'(m_valid), 64'd1);
        snap = m_data;
      end
      if (cyc >= 13 && cyc < 17) begin
        check("stall_m_valid", 64'(m_valid), 64'd1);
        check("stall_m_data_held", m_data, snap);
        check("stall_s_ready_low", 64'(s_ready), 64'd0);
      end
      acc = s_ready;
      @(posedge clk);
      #1;
      c_load = 1'b0;
      if (acc) sent++;
      cyc++;
    end
    check("stall_sent", 64'(sent), 64'd64);
    drain("stall_drain");
    check("stall_out_cnt", 64'(out_cnt), 64'd128);
    check("stall_last_cnt", 64'(last_cnt), 64'd2);
    check("stall_last_idx", 64'(last_idx), 64'd127);

    // c_load coinciding with acceptance of beat N: N sees old c, N+1 new c.
    do_reset();
    load_c(24'h000100);
    c_load  = 1'b1;
    c_value = 24'h001000;
    s_valid = 1'b1;
    s_data  = {13'h0, 13'h0, 13'h0, 13'h1FFF};
    tick();
    c_load = 1'b0;
    tick();
    s_valid = 1'b0;
`ifdef SC_ROUND_EN
    check("cload_old_c", m_data, 64'h0001_0001_0001_0021);
`else
    check("cload_old_c", m_data, 64'h0001_0001_0001_0020);
`endif
    tick();
`ifdef SC_ROUND_EN
    check("cload_new_c", m_data, 64'h0010_0010_0010_0030);
`else
    check("cload_new_c", m_data, 64'h0010_0010_0010_002F);
`endif
    drain("cload_drain");

    // Reset with two beats in flight, then a full block counted from beat 0.
    load_c(24'h00ABCD);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = pat(i + 200);
      tick();
    end
    s_valid = 1'b0;
    check("rstmid_pre_m_valid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_async_m_valid", 64'(m_valid), 64'd0);
    check("rstmid_async_m_data", m_data, 64'd0);
    check("rstmid_async_s_ready", 64'(s_ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_no_stale", 64'(m_valid), 64'd0);
    end
    load_c(24'h3C3C3C);
    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b1;
      s_data  = pat(i + 300);
      tick();
    end
    drain("rstmid_drain");
    check("rstmid_out_cnt", 64'(out_cnt), 64'd64);
    check("rstmid_last_cnt", 64'(last_cnt), 64'd1);
    check("rstmid_last_idx", 64'(last_idx), 64'd63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
